spu_reg_scoreboard: RTL and testbench
=====================================

# spu_reg_scoreboard

Register-dependency scoreboard for the dual-issue SPU. It is the consumer end of the result-forwarding chain: it counts the register writes each pipe has issued and retires them when the last forwarding stage presents the result's `rtaddr`/`wreg` for writeback. From those counts it raises per-pipe stall signals to the issue stage. It sits beside the issue logic and holds one pending-write counter per architectural register.

## Interface

**Parameters**
- `NREG`, 128: number of architectural registers; address width 7.
- `CNT_W`, 2: pending-write counter width; maximum count is 3.

**Ports**
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous reset, active-low.
- `q_e_ra`, `q_e_rb`, `q_e_rc`  in  7 each  even-pipe source register addresses.
- `q_e_use`  in  3  even source-used mask; bit 0 = ra, bit 1 = rb, bit 2 = rc.
- `q_e_rt`  in  7  even destination address.
- `q_e_wreg`  in  1  even instruction writes `q_e_rt`.
- `q_o_ra`, `q_o_rb`, `q_o_rc`, `q_o_use`, `q_o_rt`, `q_o_wreg`  in  7/7/7/3/7/1  odd-pipe equivalents.
- `q_e_vld`, `q_o_vld`  in  1 each  a query is present on that pipe this cycle.
- `iss_e`, `iss_o`  in  1 each  the instruction on the query lines issues this cycle.
- `ret_rtaddr_e`, `ret_wreg_e`  in  7/1  even result leaving the final forwarding stage.
- `ret_rtaddr_o`, `ret_wreg_o`  in  7/1  odd result leaving the final forwarding stage.
- `sb_stall_e`, `sb_stall_o`  out  1 each  combinational: hold issue on that pipe.
- `sb_idle`  out  1  registered: every counter is zero.
- `sb_overflow`  out  1  sticky: an increment was attempted on a saturated counter.
- `sb_underflow`  out  1  sticky: a decrement was attempted on a zero counter.

## Operation

- **Storage:** `cnt[0:NREG-1]`, each `CNT_W` bits. Reset sets all counters to 0.
- **Even stall.** `sb_stall_e` = `q_e_vld` AND (any used even source has `cnt != 0`, OR (`q_e_wreg` AND `cnt[q_e_rt] == 3`)).
- **Odd stall.** `sb_stall_o` = `q_o_vld` AND any of the following:
  - any used odd source has `cnt != 0`;
  - `q_o_wreg` AND `cnt[q_o_rt] == 3`;
  - intra-pair RAW: `q_e_vld & q_e_wreg` and `q_e_rt` equals a used odd source;
  - intra-pair WAW: both pipes write the same rt and `cnt[rt] >= 2`.
- **Increment** per register: `(iss_e & q_e_wreg & q_e_rt == r) + (iss_o & q_o_wreg & q_o_rt == r)`, giving 0..2.
- **Decrement** per register: `(ret_wreg_e & ret_rtaddr_e == r) + (ret_wreg_o & ret_rtaddr_o == r)`, giving 0..2.
- **Next count** = `cnt + inc - dec`, computed at 3+1 bits and then clamped:
  - result above 3: store 3 and set `sb_overflow`;
  - result below 0: store 0 and set `sb_underflow`.
- **Simultaneous issue and retire** on the same register apply net. Example: count 1, one issue and one retire → stays 1.
- **Issuing while stalled** is a protocol violation. The block still applies the update, so saturation and the sticky flags expose it.
- **Sticky flags** clear only on reset.
- **Registered outputs:** `sb_idle` is computed from next-count values and registered.

## Timing

- All stall terms are combinational from registered `cnt` and the current query inputs. There is no bypass of same-cycle retire: a register retiring in cycle N still stalls readers in cycle N and releases them in N+1.
- Issue in cycle N → count visible at edge N+1. A dependent query in N+1 stalls.
- Retire in cycle N → count decremented at edge N+1.
- **Reset values:** `sb_idle` = 1, `sb_overflow` = 0, `sb_underflow` = 0. Stalls are 0 whenever the `q_*_vld` inputs are 0.
- **Reset mid-operation:** all counters go to zero immediately (asynchronous). Retires arriving after reset for pre-reset issues set `sb_underflow`; the integration must flush the forwarding chain together with the scoreboard.
- `rt` is write-only for scoreboard purposes: a destination count below 3 never stalls by itself.

## Test plan

1. **Reset, then idle.** `rst` low, then high; no activity → `sb_idle` = 1, both stalls 0, flags 0.
2. **Basic RAW.**
   - Cycle 0: issue even with rt = 5 → cnt[5] = 1 at cycle 1, `sb_idle` = 0.
   - Cycle 1: odd query with ra = 5 used → `sb_stall_o` = 1.
   - Cycle 4: `ret_rtaddr_e` = 5, `ret_wreg_e` = 1 → stall still 1 in cycle 4, 0 in cycle 5; `sb_idle` = 1 at cycle 5.
3. **Intra-pair hazards.**
   - Even writes rt = 9 and odd uses rb = 9 in the same cycle, cnt[9] = 0 → `sb_stall_o` = 1, `sb_stall_e` = 0.
   - Both pipes write rt = 9 with cnt[9] = 2 → odd stalls.
4. **Net update.** cnt[20] = 2; in one cycle, issue odd writing 20 and retire even and odd both at 20 → cnt[20] = 1 next cycle.
5. **Saturation.**
   - Issue 3 writes to r7 → cnt = 3; a query writing r7 → stall asserted.
   - Force issue anyway → cnt stays 3 and `sb_overflow` = 1.
   - Retire r8 with cnt[8] = 0 → `sb_underflow` = 1, cnt[8] = 0.
6. **Mid-flight reset.** With cnt[3] = 2, assert `rst` low → cnt cleared immediately and `sb_idle` = 1. A later retire of r3 sets `sb_underflow`.

Source files
------------

// File: rtl/spu_reg_scoreboard_if.sv
// spu_reg_scoreboard_if: issue-query, issue, retire and
// status bundle between the SPU issue stage and its scoreboard.
interface spu_reg_scoreboard_if #(
  parameter int AW = 7
);
  logic [AW-1:0] q_e_ra;
  logic [AW-1:0] q_e_rb;
  logic [AW-1:0] q_e_rc;
  logic [2:0]    q_e_use;
  logic [AW-1:0] q_e_rt;
  logic          q_e_wreg;
  logic          q_e_vld;

  logic [AW-1:0] q_o_ra;
  logic [AW-1:0] q_o_rb;
  logic [AW-1:0] q_o_rc;
  logic [2:0]    q_o_use;
  logic [AW-1:0] q_o_rt;
  logic          q_o_wreg;
  logic          q_o_vld;

  logic          iss_e;
  logic          iss_o;

  logic [AW-1:0] ret_rtaddr_e;
  logic          ret_wreg_e;
  logic [AW-1:0] ret_rtaddr_o;
  logic          ret_wreg_o;

  logic          sb_stall_e;
  logic          sb_stall_o;
  logic          sb_idle;
  logic          sb_overflow;
  logic          sb_underflow;

  modport master (
    output q_e_ra, q_e_rb, q_e_rc, q_e_use,
    output q_e_rt, q_e_wreg, q_e_vld,
    output q_o_ra, q_o_rb, q_o_rc, q_o_use,
    output q_o_rt, q_o_wreg, q_o_vld,
    output iss_e, iss_o,
    output ret_rtaddr_e, ret_wreg_e,
    output ret_rtaddr_o, ret_wreg_o,
    input  sb_stall_e, sb_stall_o,
    input  sb_idle, sb_overflow, sb_underflow
  );

  modport slave (
    input  q_e_ra, q_e_rb, q_e_rc, q_e_use,
    input  q_e_rt, q_e_wreg, q_e_vld,
    input  q_o_ra, q_o_rb, q_o_rc, q_o_use,
    input  q_o_rt, q_o_wreg, q_o_vld,
    input  iss_e, iss_o,
    input  ret_rtaddr_e, ret_wreg_e,
    input  ret_rtaddr_o, ret_wreg_o,
    output sb_stall_e, sb_stall_o,
    output sb_idle, sb_overflow, sb_underflow
  );
endinterface

// File: rtl/spu_reg_scoreboard.sv
// spu_reg_scoreboard: per-register pending-write counters
// for the dual-issue SPU, driving per-pipe issue stalls.
module spu_reg_scoreboard #(
  parameter int NREG  = 128,
  parameter int CNT_W = 2
) (
  input logic                 clk,
  input logic                 rst,
  spu_reg_scoreboard_if.slave sb
);
  localparam int AW = $clog2(NREG);
  localparam int SW = CNT_W + 2;
  localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CTWO = CNT_W'(2);

  logic [CNT_W-1:0] cnt     [NREG];
  logic [CNT_W-1:0] cnt_nxt [NREG];
  logic [1:0]       inc     [NREG];
  logic [1:0]       dec     [NREG];
  logic [SW-1:0]    sum     [NREG];

  logic idle_q;
  logic ovf_q;
  logic unf_q;
  logic idle_nxt;
  logic ovf_hit;
  logic unf_hit;

  logic e_src;
  logic e_dst;
  logic o_src;
  logic o_dst;
  logic o_raw;
  logic o_waw;

  // Hazard terms from registered counts; no same-cycle retire bypass
  always_comb begin
    e_src = (sb.q_e_use[0] && cnt[sb.q_e_ra] != '0)
         || (sb.q_e_use[1] && cnt[sb.q_e_rb] != '0)
         || (sb.q_e_use[2] && cnt[sb.q_e_rc] != '0);
    e_dst = sb.q_e_wreg && cnt[sb.q_e_rt] == CMAX;
    o_src = (sb.q_o_use[0] && cnt[sb.q_o_ra] != '0)
         || (sb.q_o_use[1] && cnt[sb.q_o_rb] != '0)
         || (sb.q_o_use[2] && cnt[sb.q_o_rc] != '0);
    o_dst = sb.q_o_wreg && cnt[sb.q_o_rt] == CMAX;
    o_raw = sb.q_e_vld && sb.q_e_wreg
         && ((sb.q_o_use[0] && sb.q_e_rt == sb.q_o_ra)
          || (sb.q_o_use[1] && sb.q_e_rt == sb.q_o_rb)
          || (sb.q_o_use[2] && sb.q_e_rt == sb.q_o_rc));
    o_waw = sb.q_e_vld && sb.q_e_wreg && sb.q_o_wreg
         && sb.q_e_rt == sb.q_o_rt
         && cnt[sb.q_o_rt] >= CTWO;
  end

  assign sb.sb_stall_e = sb.q_e_vld && (e_src || e_dst);
  assign sb.sb_stall_o = sb.q_o_vld
                      && (o_src || o_dst || o_raw || o_waw);

  // Net issue/retire update per register, clamped at both ends
  always_comb begin
    idle_nxt = 1'b1;
    ovf_hit  = 1'b0;
    unf_hit  = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      inc[i] = {1'b0, sb.iss_e && sb.q_e_wreg
                      && sb.q_e_rt == AW'(i)}
             + {1'b0, sb.iss_o && sb.q_o_wreg
                      && sb.q_o_rt == AW'(i)};
      dec[i] = {1'b0, sb.ret_wreg_e
                      && sb.ret_rtaddr_e == AW'(i)}
             + {1'b0, sb.ret_wreg_o
                      && sb.ret_rtaddr_o == AW'(i)};
      sum[i] = {2'b00, cnt[i]}
             + {{CNT_W{1'b0}}, inc[i]}
             - {{CNT_W{1'b0}}, dec[i]};
      if (sum[i][SW-1]) begin
        cnt_nxt[i] = '0;
        unf_hit    = 1'b1;
      end else if (sum[i] > {2'b00, CMAX}) begin
        cnt_nxt[i] = CMAX;
        ovf_hit    = 1'b1;
      end else begin
        cnt_nxt[i] = sum[i][CNT_W-1:0];
      end
      idle_nxt = idle_nxt && (cnt_nxt[i] == '0);
    end
  end

  // Counter array, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) cnt[i] <= cnt_nxt[i];
    end
  end

  // Registered idle and sticky error flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idle_q <= 1'b1;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      idle_q <= idle_nxt;
      ovf_q  <= ovf_q | ovf_hit;
      unf_q  <= unf_q | unf_hit;
    end
  end

  assign sb.sb_idle      = idle_q;
  assign sb.sb_overflow  = ovf_q;
  assign sb.sb_underflow = unf_q;
endmodule

// File: tb/tb_spu_reg_scoreboard.sv
// tb_spu_reg_scoreboard: directed test of the SPU register
// scoreboard against a per-register pending-count model.
module tb_spu_reg_scoreboard;
  localparam int NREG = 128;
  localparam int CMAX = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  spu_reg_scoreboard_if #(.AW(7)) sb ();

  spu_reg_scoreboard #(
    .NREG (NREG),
    .CNT_W(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sb (sb)
  );

  int mcnt [NREG];
  bit m_ovf;
  bit m_unf;
  int total = 0;
  int bad   = 0;

  task automatic cmp(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d @%0t", nm, act, exp, $time);
    end
  endtask

  // Pending writes per register: issues add, retires remove,
  // result clamped to 0..3 with sticky out-of-range flags.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      foreach (mcnt[i]) mcnt[i] = 0;
      m_ovf = 0;
      m_unf = 0;
    end else begin
      int nc [NREG];
      nc = mcnt;
      if (sb.iss_e && sb.q_e_wreg) nc[sb.q_e_rt] += 1;
      if (sb.iss_o && sb.q_o_wreg) nc[sb.q_o_rt] += 1;
      if (sb.ret_wreg_e) nc[sb.ret_rtaddr_e] -= 1;
      if (sb.ret_wreg_o) nc[sb.ret_rtaddr_o] -= 1;
      foreach (nc[i]) begin
        if (nc[i] > CMAX) begin
          nc[i] = CMAX;
          m_ovf = 1;
        end else if (nc[i] < 0) begin
          nc[i] = 0;
          m_unf = 1;
        end
      end
      mcnt = nc;
    end
  end

  function automatic bit m_idle();
    foreach (mcnt[i]) if (mcnt[i] != 0) return 0;
    return 1;
  endfunction

  function automatic bit reads(input logic [2:0] u,
                               input logic [6:0] a,
                               input logic [6:0] b,
                               input logic [6:0] c,
                               input logic [6:0] r);
    return (u[0] && a == r) || (u[1] && b == r) || (u[2] && c == r);
  endfunction

  function automatic bit any_busy(input logic [2:0] u,
                                  input logic [6:0] a,
                                  input logic [6:0] b,
                                  input logic [6:0] c);
    return (u[0] && mcnt[a] != 0) || (u[1] && mcnt[b] != 0)
        || (u[2] && mcnt[c] != 0);
  endfunction

  function automatic bit m_stall_e();
    if (!sb.q_e_vld) return 0;
    if (any_busy(sb.q_e_use, sb.q_e_ra, sb.q_e_rb, sb.q_e_rc)) return 1;
    return sb.q_e_wreg && mcnt[sb.q_e_rt] == CMAX;
  endfunction

  function automatic bit m_stall_o();
    bit e_wr;
    if (!sb.q_o_vld) return 0;
    e_wr = sb.q_e_vld && sb.q_e_wreg;
    if (any_busy(sb.q_o_use, sb.q_o_ra, sb.q_o_rb, sb.q_o_rc)) return 1;
    if (sb.q_o_wreg && mcnt[sb.q_o_rt] == CMAX) return 1;
    if (e_wr && reads(sb.q_o_use, sb.q_o_ra, sb.q_o_rb,
                      sb.q_o_rc, sb.q_e_rt)) return 1;
    return e_wr && sb.q_o_wreg && sb.q_e_rt == sb.q_o_rt
        && mcnt[sb.q_o_rt] >= 2;
  endfunction

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    cmp("stall_e", sb.sb_stall_e, m_stall_e());
    cmp("stall_o", sb.sb_stall_o, m_stall_o());
    cmp("idle", sb.sb_idle, m_idle());
    cmp("overflow", sb.sb_overflow, m_ovf);
    cmp("underflow", sb.sb_underflow, m_unf);
  end

  task automatic clr();
    sb.q_e_ra = '0; sb.q_e_rb = '0; sb.q_e_rc = '0;
    sb.q_e_use = '0; sb.q_e_rt = '0;
    sb.q_e_wreg = 0; sb.q_e_vld = 0;
    sb.q_o_ra = '0; sb.q_o_rb = '0; sb.q_o_rc = '0;
    sb.q_o_use = '0; sb.q_o_rt = '0;
    sb.q_o_wreg = 0; sb.q_o_vld = 0;
    sb.iss_e = 0; sb.iss_o = 0;
    sb.ret_rtaddr_e = '0; sb.ret_wreg_e = 0;
    sb.ret_rtaddr_o = '0; sb.ret_wreg_o = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic e_wr(input logic [6:0] rt, input logic iss);
    sb.q_e_vld = 1; sb.q_e_wreg = 1; sb.q_e_rt = rt; sb.iss_e = iss;
  endtask

  task automatic o_wr(input logic [6:0] rt, input logic iss);
    sb.q_o_vld = 1; sb.q_o_wreg = 1; sb.q_o_rt = rt; sb.iss_o = iss;
  endtask

  initial begin
    clr();
    rst = 0;
    repeat (3) @(posedge clk);
    #1;
    cmp("t1_rst_idle", sb.sb_idle, 1);
    cmp("t1_rst_ovf", sb.sb_overflow, 0);
    cmp("t1_rst_unf", sb.sb_underflow, 0);
    rst = 1;
    step(); step();
    settle();
    cmp("t1_idle", sb.sb_idle, 1);
    cmp("t1_stall_e", sb.sb_stall_e, 0);
    cmp("t1_stall_o", sb.sb_stall_o, 0);

    // Basic RAW through the forwarding delay
    clr(); e_wr(7'd5, 1);
    settle();
    cmp("t2_e_free", sb.sb_stall_e, 0);
    step();
    clr(); sb.q_o_vld = 1; sb.q_o_ra = 7'd5; sb.q_o_use = 3'b001;
    settle();
    cmp("t2_cnt5", mcnt[5], 1);
    cmp("t2_idle0", sb.sb_idle, 0);
    cmp("t2_raw_c1", sb.sb_stall_o, 1);
    step(); step(); step();
    sb.ret_rtaddr_e = 7'd5; sb.ret_wreg_e = 1;
    settle();
    cmp("t2_raw_c4", sb.sb_stall_o, 1);
    step();
    sb.ret_wreg_e = 0;
    settle();
    cmp("t2_free_c5", sb.sb_stall_o, 0);
    cmp("t2_idle_c5", sb.sb_idle, 1);

    // Intra-pair RAW and WAW
    clr(); e_wr(7'd9, 0);
    sb.q_o_vld = 1; sb.q_o_rb = 7'd9; sb.q_o_use = 3'b010;
    settle();
    cmp("t3_raw_o", sb.sb_stall_o, 1);
    cmp("t3_raw_e", sb.sb_stall_e, 0);
    clr(); e_wr(7'd9, 1);
    step(); step();
    clr(); e_wr(7'd9, 0); o_wr(7'd9, 0);
    settle();
    cmp("t3_cnt9", mcnt[9], 2);
    cmp("t3_waw_o", sb.sb_stall_o, 1);
    cmp("t3_waw_e", sb.sb_stall_e, 0);
    clr(); sb.ret_rtaddr_e = 7'd9; sb.ret_wreg_e = 1;
    step();
    clr(); e_wr(7'd9, 0); o_wr(7'd9, 0);
    settle();
    cmp("t3_cnt9_1", mcnt[9], 1);
    cmp("t3_waw1_o", sb.sb_stall_o, 0);
    clr(); sb.ret_rtaddr_o = 7'd9; sb.ret_wreg_o = 1;
    step();

    // Net update: +1 -2 on a count of 2
    clr(); e_wr(7'd20, 1); o_wr(7'd20, 1);
    step();
    clr(); o_wr(7'd20, 1);
    sb.ret_rtaddr_e = 7'd20; sb.ret_wreg_e = 1;
    sb.ret_rtaddr_o = 7'd20; sb.ret_wreg_o = 1;
    settle();
    cmp("t4_cnt20_2", mcnt[20], 2);
    step();
    clr(); sb.q_o_vld = 1; sb.q_o_ra = 7'd20; sb.q_o_use = 3'b001;
    settle();
    cmp("t4_cnt20_1", mcnt[20], 1);
    cmp("t4_stall_o", sb.sb_stall_o, 1);
    clr(); sb.ret_rtaddr_e = 7'd20; sb.ret_wreg_e = 1;
    step();
    clr();
    settle();
    cmp("t4_idle", sb.sb_idle, 1);

    // Saturation, overflow and underflow
    clr(); e_wr(7'd7, 1);
    step(); step(); step();
    clr(); e_wr(7'd7, 0);
    settle();
    cmp("t5_cnt7", mcnt[7], 3);
    cmp("t5_sat_e", sb.sb_stall_e, 1);
    cmp("t5_ovf0", sb.sb_overflow, 0);
    sb.iss_e = 1;
    step();
    clr(); o_wr(7'd7, 0);
    settle();
    cmp("t5_ovf1", sb.sb_overflow, 1);
    cmp("t5_cnt7_sat", mcnt[7], 3);
    cmp("t5_sat_o", sb.sb_stall_o, 1);
    clr(); sb.ret_rtaddr_e = 7'd8; sb.ret_wreg_e = 1;
    step();
    clr();
    settle();
    cmp("t5_unf1", sb.sb_underflow, 1);
    cmp("t5_cnt8", mcnt[8], 0);
    sb.ret_rtaddr_e = 7'd7; sb.ret_wreg_e = 1;
    sb.ret_rtaddr_o = 7'd7; sb.ret_wreg_o = 1;
    step();
    sb.ret_wreg_o = 0;
    step();
    clr();
    settle();
    cmp("t5_idle", sb.sb_idle, 1);

    // Asynchronous reset mid-flight
    clr(); e_wr(7'd3, 1); o_wr(7'd3, 1);
    step();
    clr(); sb.q_o_vld = 1; sb.q_o_ra = 7'd3; sb.q_o_use = 3'b001;
    settle();
    cmp("t6_cnt3", mcnt[3], 2);
    cmp("t6_idle0", sb.sb_idle, 0);
    cmp("t6_stall", sb.sb_stall_o, 1);
    rst = 0;
    #1;
    cmp("t6_rst_idle", sb.sb_idle, 1);
    cmp("t6_rst_unf", sb.sb_underflow, 0);
    cmp("t6_rst_ovf", sb.sb_overflow, 0);
    cmp("t6_rst_stall", sb.sb_stall_o, 0);
    cmp("t6_rst_cnt3", mcnt[3], 0);
    step();
    rst = 1;
    step();
    clr(); sb.ret_rtaddr_e = 7'd3; sb.ret_wreg_e = 1;
    step();
    clr();
    settle();
    cmp("t6_unf", sb.sb_underflow, 1);
    cmp("t6_idle", sb.sb_idle, 1);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
